// File: rtl/median_window_gen.sv
// median_window_gen: streaming 3x3 neighbourhood generator that feeds Median_Filter from a raster pixel stream.
// Build option: define MEDIAN_WIN_BORDER_REPLICATE_EN to clamp out-of-image taps to the nearest pixel instead of 0.
module median_window_gen #(
    parameter int LINE_LEN  = 554,
    parameter int NUM_LINES = 430,
    parameter int DW        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [DW-1:0]      in_data,
    output logic               in_ready,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [DW-1:0]      data_in_0,
    output logic [DW-1:0]      data_in_1,
    output logic [DW-1:0]      data_in_2,
    output logic [DW-1:0]      data_in_3,
    output logic [DW-1:0]      data_in_4,
    output logic [DW-1:0]      data_in_5,
    output logic [DW-1:0]      data_in_6,
    output logic [DW-1:0]      data_in_7,
    output logic [DW-1:0]      data_in_8,
    output logic signed [31:0] pixel,
    output logic               done
);
    localparam int PW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [31:0] TOTAL   = 32'(LINE_LEN * NUM_LINES);
    localparam logic [31:0] LAST_IN = 32'(LINE_LEN * NUM_LINES - 1);
    localparam logic [31:0] PRIME   = 32'(LINE_LEN + 1);

    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;
    state_t state, state_nx;

    logic [DW-1:0]           lb1 [LINE_LEN];
    logic [DW-1:0]           lb2 [LINE_LEN];
    logic [PW-1:0]           wptr;
    logic [1:0][2:0][DW-1:0] hist;
    logic [2:0][2:0][DW-1:0] win;
    logic [2:0][DW-1:0]      new_col;
    logic [8:0][DW-1:0]      taps_d, taps_q;
    logic [31:0]             in_cnt, gen_idx;
    logic [PW-1:0]           gen_pos;
    logic [LW-1:0]           gen_line;
    logic [2:0]              row_ok, col_ok;
    logic                    out_last, out_free, accept, flush_gen, step, gen;

    assign out_free  = !win_valid || win_ready;
    assign in_ready  = (state == FILL || state == RUN) && out_free;
    assign accept    = in_valid && in_ready;
    assign flush_gen = (state == FLUSH) && out_free && (gen_idx != TOTAL);
    assign step      = accept || flush_gen;
    assign gen       = flush_gen || (accept && in_cnt >= PRIME);
    assign done      = (state == FLUSH) && win_valid && win_ready && out_last;

    // Newest column sits at (l+1, p+1); the line buffers supply rows l and l-1 of that column.
    assign new_col = {(state == FLUSH) ? {DW{1'b0}} : in_data, lb1[wptr], lb2[wptr]};
    assign win     = {new_col, hist[1], hist[0]};

    assign row_ok = {gen_line != LW'(NUM_LINES - 1), 1'b1, gen_line != '0};
    assign col_ok = {gen_pos != PW'(LINE_LEN - 1), 1'b1, gen_pos != '0};

    for (genvar c = 0; c < 3; c++) begin : g_col
        for (genvar r = 0; r < 3; r++) begin : g_row
`ifdef MEDIAN_WIN_BORDER_REPLICATE_EN
            logic [1:0] rs, cs;
            assign rs = row_ok[r] ? 2'(r) : 2'd1;
            assign cs = col_ok[c] ? 2'(c) : 2'd1;
            assign taps_d[c*3+r] = win[cs][rs];
`else
            assign taps_d[c*3+r] = (row_ok[r] && col_ok[c]) ? win[c][r] : {DW{1'b0}};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (step) begin
            lb1[wptr] <= new_col[2];
            lb2[wptr] <= lb1[wptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt    <= '0;
            gen_idx   <= '0;
            gen_pos   <= '0;
            gen_line  <= '0;
            wptr      <= '0;
            hist      <= '0;
            taps_q    <= '0;
            pixel     <= '0;
            win_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if ((state == IDLE || state == DONE) && start) begin
                in_cnt   <= '0;
                gen_idx  <= '0;
                gen_pos  <= '0;
                gen_line <= '0;
                wptr     <= '0;
            end else if (step) begin
                wptr <= (wptr == PW'(LINE_LEN - 1)) ? '0 : wptr + 1'b1;
                hist <= {new_col, hist[1]};
                if (accept) in_cnt <= in_cnt + 32'd1;
            end
            if (gen) begin
                taps_q    <= taps_d;
                pixel     <= $signed(gen_idx);
                out_last  <= (gen_idx == LAST_IN);
                win_valid <= 1'b1;
                gen_idx   <= gen_idx + 32'd1;
                if (gen_pos == PW'(LINE_LEN - 1)) begin
                    gen_pos  <= '0;
                    gen_line <= gen_line + 1'b1;
                end else begin
                    gen_pos <= gen_pos + 1'b1;
                end
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = FILL;
            FILL: begin
                if (accept && in_cnt == LAST_IN)    state_nx = FLUSH;
                else if (accept && in_cnt == PRIME) state_nx = RUN;
            end
            RUN:   if (accept && in_cnt == LAST_IN) state_nx = FLUSH;
            FLUSH: if (done) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    assign data_in_0 = taps_q[0];
    assign data_in_1 = taps_q[1];
    assign data_in_2 = taps_q[2];
    assign data_in_3 = taps_q[3];
    assign data_in_4 = taps_q[4];
    assign data_in_5 = taps_q[5];
    assign data_in_6 = taps_q[6];
    assign data_in_7 = taps_q[7];
    assign data_in_8 = taps_q[8];
endmodule

// File: tb/tb_median_window_gen.sv
// tb_median_window_gen: drives frames through median_window_gen with random stalls and compares
// every window against a coordinate-level neighbourhood model.
`timescale 1ns/1ps
module tb_median_window_gen;
    localparam int L = 4, N = 3, DW = 8, TOT = L * N;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, win_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, win_valid, done;
    logic [DW-1:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
    logic signed [31:0] pixel;
    logic [7:0] fr [TOT];
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    median_window_gen #(.LINE_LEN(L), .NUM_LINES(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .win_valid(win_valid), .win_ready(win_ready),
        .data_in_0(d0), .data_in_1(d1), .data_in_2(d2), .data_in_3(d3), .data_in_4(d4),
        .data_in_5(d5), .data_in_6(d6), .data_in_7(d7), .data_in_8(d8),
        .pixel(pixel), .done(done)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function logic [71:0] taps_now();
        return {d8, d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    // Tap k looks at line offset (k%3)-1 and position offset (k/3)-1 around the centre.
    function automatic logic [71:0] model_win(input int w);
        logic [8:0][7:0] t;
        int l, p, tl, tp;
        l = w / L;
        p = w % L;
        for (int k = 0; k < 9; k++) begin
            tl = l + (k % 3) - 1;
            tp = p + (k / 3) - 1;
`ifdef MEDIAN_WIN_BORDER_REPLICATE_EN
            tl = (tl < 0) ? 0 : (tl >= N) ? N - 1 : tl;
            tp = (tp < 0) ? 0 : (tp >= L) ? L - 1 : tp;
            t[k] = fr[tl * L + tp];
`else
            t[k] = (tl < 0 || tl >= N || tp < 0 || tp >= L) ? 8'h00 : fr[tl * L + tp];
`endif
        end
        return t;
    endfunction

    task automatic run_frame(input bit stall, input bit spec_pts, input bit mid_start);
        int in_idx = 0, w = 0, cyc = 0;
        bit started_mid = 0, prev_stall = 0;
        logic [71:0] prev_taps;
        logic signed [31:0] prev_pix;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (w < TOT && cyc < 2000) begin
            in_valid  = (in_idx < TOT) && (!stall || $urandom_range(0, 3) != 0);
            in_data   = (in_idx < TOT) ? fr[in_idx] : 8'h00;
            win_ready = !stall || ($urandom_range(0, 2) != 0);
            start     = mid_start && !started_mid && in_idx == 8;
            if (start) started_mid = 1;
            #1;
            if (prev_stall) begin
                chk("stall_taps", taps_now(), prev_taps);
                chk("stall_pixel", pixel, prev_pix);
            end
            if (in_idx <= L + 1) chk("fill_quiet", win_valid, 0);
            if (win_valid && !win_ready) chk("stall_in_ready", in_ready, 0);
            if (in_idx == TOT) chk("flush_in_ready", in_ready, 0);
            if (win_valid && win_ready) begin
                chk("win_pixel", pixel, w);
                chk("win_taps", taps_now(), model_win(w));
                chk("done", done, (w == TOT - 1));
                if (!stall && in_idx < TOT) chk("latency", in_idx, w + L + 2);
                if (spec_pts) begin
`ifdef MEDIAN_WIN_BORDER_REPLICATE_EN
                    if (w == 0) chk("w0_repl", taps_now(), 72'h15_11_11_14_10_10_14_10_10);
`else
                    if (w == 0)  chk("w0_zero", taps_now(), 72'h15_11_00_14_10_00_00_00_00);
                    if (w == 11) chk("w11_zero", taps_now(), 72'h00_00_00_00_1B_17_00_1A_16);
`endif
                    if (w == 5) chk("w5_inner", taps_now(), 72'h1A_16_12_19_15_11_18_14_10);
                end
                w++;
            end else begin
                chk("done_idle", done, 0);
            end
            prev_stall = win_valid && !win_ready;
            prev_taps  = taps_now();
            prev_pix   = pixel;
            if (in_valid && in_ready) in_idx++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("timeout", (cyc < 2000), 1);
        in_valid  = 1'b0;
        win_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_valid", win_valid, 0);
            chk("post_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("win_count", w, TOT);
    endtask

    task automatic reset_mid();
        int acc = 0, cyc = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        in_valid  = 1'b1;
        win_ready = 1'b1;
        while (acc < 7 && cyc < 100) begin
            in_data = fr[acc];
            #1;
            if (in_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", win_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", win_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_done", done, 0);
        chk("arst_pixel", pixel, 0);
        chk("arst_taps", taps_now(), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", win_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_pixel", pixel, 0);
        chk("rst_taps", taps_now(), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        #1 chk("idle_in_ready", in_ready, 0);
        @(negedge clk);

        for (int i = 0; i < TOT; i++) fr[i] = 8'(i + 'h10);
        run_frame(0, 1, 0);
        run_frame(1, 0, 0);
        for (int i = 0; i < TOT; i++) fr[i] = 8'($urandom);
        run_frame(1, 0, 0);

        for (int i = 0; i < TOT; i++) fr[i] = 8'(i + 'h10);
        reset_mid();
        for (int i = 0; i < TOT; i++) fr[i] = 8'($urandom) | 8'h80;
        run_frame(0, 0, 0);

        for (int i = 0; i < TOT; i++) fr[i] = 8'(i + 'h10);
        run_frame(0, 1, 1);
        run_frame(0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/median_window_gen.md
Name: median_window_gen

Overview:
- Streaming 3x3 neighbourhood generator that sits in front of Median_Filter.
- Accepts a raster pixel stream, one pixel per handshake, and produces the nine data_in_0..data_in_8 window operands plus the centre index (pixel) in the neighbour ordering Median_Filter expects.
- Replaces array-indexed frame memory with two line buffers, so the filter can be fed from a camera or DMA stream.
- Handles image borders and flushes the final line after input ends.

Parameters:
LINE_LEN, 554, pixels per line (fast dimension; stride between adjacent lines)
NUM_LINES, 430, lines per frame (slow dimension)
DW, 8, pixel width in bits

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms a new frame (ignored unless IDLE or DONE)
in_valid  in  1  input pixel valid
in_data  in  DW  input pixel, raster order (fast index first)
in_ready  out  1  input pixel accepted when in_valid && in_ready
win_valid  out  1  window outputs valid
win_ready  in  1  consumer accepts window when win_valid && win_ready
data_in_0..data_in_8  out  DW each  window taps (ordering below)
pixel  out  32 signed  raster index of window centre, line*LINE_LEN+pos
done  out  1  one-cycle pulse with the final window's handshake

Behaviour:
- Coordinates: centre (l,p) with line l and position p. Tap k has position offset (k/3)-1 and line offset (k%3)-1.
  - k=0 is (l-1,p-1); k=1 is (l,p-1); k=2 is (l+1,p-1).
  - k=4 is the centre; k=8 is (l+1,p+1).
- Storage: two LINE_LEN x DW line buffers (circular, one shared write pointer) plus a 3x3 register array shifted one column per accepted input.
- FSM:
  - IDLE: start moves to FILL and clears pos, line and output counters.
  - FILL: accepts inputs with win_valid=0 until sample index LINE_LEN+1 has been accepted, then moves to RUN.
  - RUN: each accepted input at raster index n yields the window centred on n-LINE_LEN-1, presented the next cycle. After sample LINE_LEN*NUM_LINES-1 is accepted, moves to FLUSH.
  - FLUSH: in_ready=0. Emits the remaining LINE_LEN+1 windows, one per win handshake, fed with a virtual out-of-image column.
  - DONE: entered after the final window handshake; in_ready=0, win_valid=0. start re-arms.
- Window count per frame is exactly LINE_LEN*NUM_LINES; pixel increments by 1 per window, starting at 0.
- Backpressure:
  - in_ready = (state is FILL or RUN) && (!win_valid || win_ready).
  - Outputs hold stable while win_valid && !win_ready.
- Borders: any tap with line<0, line>=NUM_LINES, pos<0 or pos>=LINE_LEN outputs 0.
  - Line wrap: taps from the previous line's tail never leak into pos 0, and vice versa.
- start while in FILL, RUN or FLUSH: ignored.
- Reset mid-frame: immediately IDLE; all line-buffer contents are treated as invalid.
- Reset values: in_ready=0, win_valid=0, done=0, pixel=0, data_in_0..8=0, state IDLE.

Optional Feature:
- Macro: MEDIAN_WIN_BORDER_REPLICATE_EN.
- Defined: out-of-image taps take the value of the nearest in-image pixel, with coordinates clamped independently in line and position.
- Undefined: out-of-image taps are 0, as specified above.
- Latency, handshake and window count are identical in both builds.

Test Plan:
- LINE_LEN=4, NUM_LINES=3, in_data=index+0x10, win_ready=1, macro off: the first window has pixel=0 and taps 00,00,00,00,10,14,00,11,15; exactly 12 windows are emitted; done pulses with pixel=11.
- Same stimulus, macro on: window pixel=0 has taps 10,10,14,10,10,14,11,11,15.
- Same stimulus: window pixel=5 has taps 10,14,18,11,15,19,12,16,1A. Window pixel=11 (macro off) has taps 16,1A,00,17,1B,00,00,00,00, and is emitted in FLUSH with in_ready=0.
- Random win_ready stalls and in_valid gaps: window sequence is identical to the no-stall run; outputs are stable while stalled; no input is accepted while a window is stalled.
- Assert rst_n low after 7 inputs, then start a new frame: outputs clear asynchronously, and the new frame's windows contain no old-frame values.
- start pulse during RUN: ignored, window count stays 12. A start after done re-runs the frame with identical results.
